// File: rtl/reg_file_burst_reader_if.sv
// rtl/reg_file_burst_reader_if.sv - bus bundle between the burst reader, its reg_file and its consumer
// Purpose: groups the control, reg_file read port and output stream signals of the burst reader.
// Signals:
//   start, base_addr, len  burst request (into the reader)
//   busy, done             burst status (out of the reader)
//   r_addr / r_data        reg_file read port (address out, combinational data in)
//   m_data, m_valid        output stream (out of the reader)
//   m_ready                output stream backpressure (into the reader)
// Modports: master = the burst reader, slave = its surroundings.
interface reg_file_burst_reader_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, base_addr, len, r_data, m_ready,
    output r_addr, m_data, m_valid, busy, done
  );

  modport slave (
    output start, base_addr, len, r_data, m_ready,
    input  r_addr, m_data, m_valid, busy, done
  );
endinterface

// File: rtl/reg_file_burst_reader.sv
// rtl/reg_file_burst_reader.sv - burst read engine streaming reg_file entries through a registered output stage
// Purpose: on start, reads len consecutive reg_file entries from base_addr (address wraps modulo
//   2**ADDR_WIDTH, len clipped to 2**ADDR_WIDTH) and emits each on a valid/ready stream.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    reg_file_burst_reader_if.master: start/base_addr/len in, busy/done out,
//          r_addr out / r_data in, m_data/m_valid out, m_ready in
module reg_file_burst_reader #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input logic                     clk,
  input logic                     reset,
  reg_file_burst_reader_if.master bus
);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  localparam logic [ADDR_WIDTH:0]   DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ONE_R = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q;
  logic                  done_q;
  logic                  out_free;
  logic                  load;
  logic [ADDR_WIDTH:0]   len_clip;

  // The output register can take a new beat when it is empty or being drained this cycle.
  assign out_free = !m_valid_q || bus.m_ready;
  assign load     = (state == S_ACTIVE) && (remaining != '0) && out_free;
  assign len_clip = (bus.len > DEPTH) ? DEPTH : bus.len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == S_IDLE) begin
        if (bus.start) begin
          if (bus.len != '0) begin
            addr      <= bus.base_addr;
            remaining <= len_clip;
            state     <= S_ACTIVE;
          end else begin
            // Empty burst: completion pulse only, no beats.
            done_q <= 1'b1;
          end
        end
      end else begin
        if (load) begin
          m_data_q  <= bus.r_data;
          m_valid_q <= 1'b1;
          addr      <= addr + ONE_A;
          remaining <= remaining - ONE_R;
        end else if (m_valid_q && bus.m_ready) begin
          m_valid_q <= 1'b0;
        end
        // All beats loaded and the last one is leaving (or already gone): finish.
        if ((remaining == '0) && out_free) begin
          m_valid_q <= 1'b0;
          done_q    <= 1'b1;
          state     <= S_IDLE;
        end
      end
    end
  end

  assign bus.r_addr  = addr;
  assign bus.m_data  = m_data_q;
  assign bus.m_valid = m_valid_q;
  assign bus.busy    = (state != S_IDLE);
  assign bus.done    = done_q;
endmodule

// File: tb/tb_reg_file_burst_reader.sv
// tb/tb_reg_file_burst_reader.sv - self-checking bench for reg_file_burst_reader
module tb_reg_file_burst_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] mem [8];
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  reg_file_burst_reader_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

  reg_file_burst_reader #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.r_data = mem[bus.r_addr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: inputs only change just after posedge, so values seen at
  // negedge are what the DUT samples at the next posedge.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, bus.m_valid}, 32'd1);
        check("stall_data", {24'd0, bus.m_data}, {24'd0, prev_data});
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", {24'd0, bus.m_data}, 32'hFFFF_FFFF);
        else check("beat", {24'd0, bus.m_data}, {24'd0, exp_q.pop_front()});
      end
      if (bus.done) done_cnt++;
      prev_stall <= bus.m_valid && !bus.m_ready;
      prev_data  <= bus.m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start for one cycle and queue the expected beats from the bench's memory image.
  task automatic issue(input logic [2:0] base, input logic [3:0] len);
    int n;
    logic [2:0] a;
    n = (len > 4'd8) ? 8 : int'(len);
    a = base;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(8'(a) * 8'h11);
      a = a + 3'd1;
    end
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.len = len;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int dc0);
    int c;
    c = 0;
    while (!bus.done && c < 200) begin
      tick();
      c++;
    end
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    tick();
    check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done_low"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_drained"}, exp_q.size(), 32'd0);
    check({tag, "_one_pulse"}, done_cnt - dc0, 32'd1);
  endtask

  initial begin
    int dc;
    for (int i = 0; i < 8; i++) mem[i] = 8'(i * 8'h11);
    bus.start = 1'b0;
    bus.base_addr = 3'd0;
    bus.len = 4'd0;
    bus.m_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // 1. reset state
    tick();
    check("rst_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_raddr", {29'd0, bus.r_addr}, 32'd0);

    // 2. base=2 len=4, cycle-exact
    dc = done_cnt;
    issue(3'd2, 4'd4);
    check("s2_busy", {31'd0, bus.busy}, 32'd1);
    check("s2_lat_valid", {31'd0, bus.m_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s2_valid", {31'd0, bus.m_valid}, 32'd1);
      check("s2_data", {24'd0, bus.m_data}, 32'h22 + 32'(i) * 32'h11);
    end
    tick();
    check("s2_done", {31'd0, bus.done}, 32'd1);
    check("s2_idle", {31'd0, bus.busy}, 32'd0);
    check("s2_valid_off", {31'd0, bus.m_valid}, 32'd0);
    tick();
    check("s2_done_low", {31'd0, bus.done}, 32'd0);
    check("s2_drained", exp_q.size(), 32'd0);
    check("s2_one_pulse", done_cnt - dc, 32'd1);

    // 3. wrap, full depth, clipped length
    dc = done_cnt; issue(3'd6, 4'd4); wait_done("s3_wrap", dc);
    dc = done_cnt; issue(3'd0, 4'd8); wait_done("s3_full", dc);
    dc = done_cnt; issue(3'd0, 4'd9); wait_done("s3_clip", dc);
    dc = done_cnt; issue(3'd5, 4'd15); wait_done("s3_clip15", dc);

    // 4. backpressure
    dc = done_cnt;
    issue(3'd0, 4'd5);
    for (int c = 0; c < 100 && !bus.done; c++) begin
      bus.m_ready = (c % 3 == 2) || (c % 5 == 0);
      tick();
    end
    bus.m_ready = 1'b1;
    wait_done("s4_stall", dc);

    // 5. start while busy is ignored; len=0 gives a bare done pulse
    dc = done_cnt;
    issue(3'd4, 4'd3);
    tick();
    bus.start = 1'b1; bus.base_addr = 3'd1; bus.len = 4'd2;
    tick();
    bus.start = 1'b0;
    wait_done("s5_ignore", dc);
    dc = done_cnt;
    issue(3'd3, 4'd0);
    check("s5_len0_done", {31'd0, bus.done}, 32'd1);
    check("s5_len0_busy", {31'd0, bus.busy}, 32'd0);
    check("s5_len0_valid", {31'd0, bus.m_valid}, 32'd0);
    tick();
    check("s5_len0_done_low", {31'd0, bus.done}, 32'd0);
    check("s5_len0_valid2", {31'd0, bus.m_valid}, 32'd0);
    check("s5_len0_pulse", done_cnt - dc, 32'd1);

    // 6. reset mid-burst
    dc = done_cnt;
    issue(3'd1, 4'd6);
    tick();
    tick();
    tick();
    check("s6_two_beats", exp_q.size(), 32'd4);
    reset = 1'b1;
    #1;
    check("s6_valid_drop", {31'd0, bus.m_valid}, 32'd0);
    check("s6_busy_drop", {31'd0, bus.busy}, 32'd0);
    check("s6_raddr_rst", {29'd0, bus.r_addr}, 32'd0);
    exp_q.delete();
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("s6_no_done", done_cnt - dc, 32'd0);
    dc = done_cnt;
    issue(3'd3, 4'd2);
    wait_done("s6_after", dc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
